// File: rtl/armleosoc_axi_simple_initiator.sv
// rtl/armleosoc_axi_simple_initiator.sv - single-outstanding AXI4 initiator for one-word commands
module armleosoc_axi_simple_initiator #(
  parameter int ADDR_WIDTH     = 34,
  parameter int ID_WIDTH       = 4,
  parameter int TRANSACTION_ID = 0
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_address,
  input  logic [31:0]           cmd_write_data,
  input  logic [3:0]            cmd_write_byteenable,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_read_data,
  output logic                  rsp_error,

  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [ADDR_WIDTH-1:0] axi_awaddr,
  output logic [ID_WIDTH-1:0]   axi_awid,
  output logic [7:0]            axi_awlen,
  output logic [2:0]            axi_awsize,
  output logic [1:0]            axi_awburst,
  output logic [0:0]            axi_awlock,
  output logic [2:0]            axi_awprot,

  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  output logic [31:0]           axi_wdata,
  output logic [3:0]            axi_wstrb,
  output logic                  axi_wlast,

  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  input  logic [1:0]            axi_bresp,
  input  logic [ID_WIDTH-1:0]   axi_bid,

  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic [ID_WIDTH-1:0]   axi_arid,
  output logic [7:0]            axi_arlen,
  output logic [2:0]            axi_arsize,
  output logic [1:0]            axi_arburst,
  output logic [0:0]            axi_arlock,
  output logic [2:0]            axi_arprot,

  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  input  logic [1:0]            axi_rresp,
  input  logic [ID_WIDTH-1:0]   axi_rid,
  input  logic [31:0]           axi_rdata,
  input  logic                  axi_rlast
);

  localparam int DATA_WIDTH   = 32;
  localparam int DATA_STROBES = DATA_WIDTH / 8;
  localparam logic [ID_WIDTH-1:0] TID = ID_WIDTH'(TRANSACTION_ID);

  typedef enum logic [2:0] {
    IDLE, WRITE, WRITE_RESP, READ_ADDR, READ_DATA, RESPOND
  } state_t;

  state_t                  state, state_next;
  logic                    aw_done, aw_done_next;
  logic                    w_done, w_done_next;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_STROBES-1:0] wstrb_q;
  logic [DATA_WIDTH-1:0]   rsp_data_q;
  logic                    rsp_err_q;

  assign axi_awaddr  = addr_q;
  assign axi_awid    = TID;
  assign axi_awlen   = 8'd0;
  assign axi_awsize  = 3'b010;
  assign axi_awburst = 2'b01;
  assign axi_awlock  = 1'b0;
  assign axi_awprot  = 3'b000;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_wlast   = 1'b1;
  assign axi_araddr  = addr_q;
  assign axi_arid    = TID;
  assign axi_arlen   = 8'd0;
  assign axi_arsize  = 3'b010;
  assign axi_arburst = 2'b01;
  assign axi_arlock  = 1'b0;
  assign axi_arprot  = 3'b000;

  assign rsp_read_data = rsp_data_q;
  assign rsp_error     = rsp_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_next;
      aw_done <= aw_done_next;
      w_done  <= w_done_next;
    end
  end

  // Every handshake output is decoded from state so reset clears them asynchronously.
  always_comb begin
    state_next   = state;
    aw_done_next = aw_done;
    w_done_next  = w_done;
    cmd_ready    = 1'b0;
    axi_awvalid  = 1'b0;
    axi_wvalid   = 1'b0;
    axi_bready   = 1'b0;
    axi_arvalid  = 1'b0;
    axi_rready   = 1'b0;
    rsp_valid    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid && !rst) begin
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          state_next   = cmd_write ? WRITE : READ_ADDR;
        end
      end
      WRITE: begin
        axi_awvalid = !aw_done;
        axi_wvalid  = !w_done;
        if (axi_awvalid && axi_awready) aw_done_next = 1'b1;
        if (axi_wvalid && axi_wready) w_done_next = 1'b1;
        if (aw_done_next && w_done_next) state_next = WRITE_RESP;
      end
      WRITE_RESP: begin
        axi_bready = 1'b1;
        if (axi_bvalid) state_next = RESPOND;
      end
      READ_ADDR: begin
        axi_arvalid = 1'b1;
        if (axi_arready) state_next = READ_DATA;
      end
      READ_DATA: begin
        axi_rready = 1'b1;
        if (axi_rvalid) state_next = RESPOND;
      end
      RESPOND: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        addr_q  <= cmd_address;
        wdata_q <= cmd_write_data;
        wstrb_q <= cmd_write_byteenable;
      end
      if (state == WRITE_RESP && axi_bvalid) begin
        rsp_data_q <= '0;
        rsp_err_q  <= (axi_bresp != 2'b00) || (axi_bid != TID);
      end
      if (state == READ_DATA && axi_rvalid) begin
        rsp_data_q <= axi_rdata;
        rsp_err_q  <= (axi_rresp != 2'b00) || (axi_rid != TID) || !axi_rlast;
      end
    end
  end

`ifdef FORMAL
  // Misaligned word addresses are still issued but are a caller protocol violation.
  assert property (@(posedge clk) disable iff (rst)
    (cmd_valid && cmd_ready) |-> (cmd_address[1:0] == 2'b00));
`endif

endmodule

// File: tb/tb_armleosoc_axi_simple_initiator.sv
// tb/tb_armleosoc_axi_simple_initiator.sv - randomized self-checking bench for the AXI simple initiator
module tb_armleosoc_axi_simple_initiator;
  localparam int AW = 34;
  localparam int IW = 4;
  localparam logic [IW-1:0] TID = 4'd0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_address;
  logic [31:0]   cmd_write_data;
  logic [3:0]    cmd_write_byteenable;
  logic          rsp_valid, rsp_ready, rsp_error;
  logic [31:0]   rsp_read_data;
  logic          axi_awvalid, axi_awready;
  logic [AW-1:0] axi_awaddr;
  logic [IW-1:0] axi_awid;
  logic [7:0]    axi_awlen;
  logic [2:0]    axi_awsize;
  logic [1:0]    axi_awburst;
  logic [0:0]    axi_awlock;
  logic [2:0]    axi_awprot;
  logic          axi_wvalid, axi_wready, axi_wlast;
  logic [31:0]   axi_wdata;
  logic [3:0]    axi_wstrb;
  logic          axi_bvalid, axi_bready;
  logic [1:0]    axi_bresp;
  logic [IW-1:0] axi_bid;
  logic          axi_arvalid, axi_arready;
  logic [AW-1:0] axi_araddr;
  logic [IW-1:0] axi_arid;
  logic [7:0]    axi_arlen;
  logic [2:0]    axi_arsize;
  logic [1:0]    axi_arburst;
  logic [0:0]    axi_arlock;
  logic [2:0]    axi_arprot;
  logic          axi_rvalid, axi_rready, axi_rlast;
  logic [1:0]    axi_rresp;
  logic [IW-1:0] axi_rid;
  logic [31:0]   axi_rdata;

  armleosoc_axi_simple_initiator #(
    .ADDR_WIDTH(AW), .ID_WIDTH(IW), .TRANSACTION_ID(0)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_write_data(cmd_write_data),
    .cmd_write_byteenable(cmd_write_byteenable),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_read_data(rsp_read_data), .rsp_error(rsp_error),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_awid(axi_awid), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awlock(axi_awlock), .axi_awprot(axi_awprot),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp), .axi_bid(axi_bid),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_arid(axi_arid), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arlock(axi_arlock), .axi_arprot(axi_arprot),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rresp(axi_rresp),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rlast(axi_rlast)
  );

  int tests = 0;
  int fails = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic slave_quiet();
    axi_awready = 1'b0; axi_wready = 1'b0; axi_arready = 1'b0;
    axi_bvalid = 1'b0; axi_bresp = 2'b00; axi_bid = '0;
    axi_rvalid = 1'b0; axi_rresp = 2'b00; axi_rid = '0; axi_rdata = '0; axi_rlast = 1'b0;
    rsp_ready = 1'b0;
  endtask

  // One command end to end; the slave responds after the given delays and the
  // expected response is derived from what the slave was told to return.
  task automatic do_txn(input bit wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, input int aw_dly, input int w_dly,
                        input int resp_dly, input int rsp_hold, input logic [1:0] resp,
                        input logic [IW-1:0] rid_v, input bit last_v, input logic [31:0] rd,
                        output int lat);
    int aw_hs, w_hs, ar_hs, resp_hs, aw_cnt, w_cnt, ar_cnt, resp_cnt, rsp_cnt;
    bit aw_pend, w_pend, ar_pend, done;
    logic [31:0] exp_data;
    bit exp_err;
    exp_data = wr ? 32'd0 : rd;
    exp_err  = (resp != 2'b00) || (rid_v != TID) || (!wr && !last_v);
    aw_hs = 0; w_hs = 0; ar_hs = 0; resp_hs = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; resp_cnt = 0; rsp_cnt = 0;
    aw_pend = 0; w_pend = 0; ar_pend = 0; done = 0; lat = -1;
    @(negedge clk);
    check_eq("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_address = addr;
    cmd_write_data = wd; cmd_write_byteenable = strb;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_write = 1'($urandom);
    cmd_address = AW'({$urandom, $urandom}); cmd_write_data = $urandom;
    cmd_write_byteenable = 4'($urandom);
    for (int k = 1; k <= 100 && !done; k++) begin
      check_eq("cmd_ready_busy", 64'(cmd_ready), 64'd0);
      if (wr) begin
        check_eq("wrong_chan_wr", 64'({axi_arvalid, axi_rready}), 64'd0);
        axi_rvalid = 1'($urandom); axi_rdata = $urandom; axi_rresp = 2'($urandom);
        axi_rid = IW'($urandom); axi_rlast = 1'($urandom);
        if (aw_hs == 1 && w_hs == 1 && resp_hs == 0) begin
          axi_bvalid = (resp_cnt >= resp_dly); resp_cnt++;
          axi_bresp = resp; axi_bid = rid_v;
          if (axi_bvalid && axi_bready) resp_hs++;
        end else axi_bvalid = 1'b0;
      end else begin
        check_eq("wrong_chan_rd", 64'({axi_awvalid, axi_wvalid, axi_bready}), 64'd0);
        axi_bvalid = 1'($urandom); axi_bresp = 2'($urandom); axi_bid = IW'($urandom);
        if (ar_hs == 1 && resp_hs == 0) begin
          axi_rvalid = (resp_cnt >= resp_dly); resp_cnt++;
          axi_rresp = resp; axi_rid = rid_v; axi_rlast = last_v;
          axi_rdata = axi_rvalid ? rd : $urandom;
          if (axi_rvalid && axi_rready) resp_hs++;
        end else axi_rvalid = 1'b0;
      end
      if (aw_pend) check_eq("aw_held", 64'(axi_awvalid), 64'd1);
      if (aw_hs > 0) check_eq("aw_dropped", 64'(axi_awvalid), 64'd0);
      axi_awready = 1'b0;
      if (axi_awvalid) begin
        check_eq("awaddr", 64'(axi_awaddr), 64'(addr));
        check_eq("aw_fields", 64'({axi_awid, axi_awlen, axi_awsize, axi_awburst, axi_awlock, axi_awprot}),
                 64'({TID, 8'd0, 3'b010, 2'b01, 1'b0, 3'b000}));
        axi_awready = (aw_cnt >= aw_dly); aw_cnt++;
        if (axi_awready) aw_hs++;
      end
      aw_pend = axi_awvalid && !axi_awready;
      if (w_pend) check_eq("w_held", 64'(axi_wvalid), 64'd1);
      if (w_hs > 0) check_eq("w_dropped", 64'(axi_wvalid), 64'd0);
      axi_wready = 1'b0;
      if (axi_wvalid) begin
        check_eq("w_beat", 64'({axi_wdata, axi_wstrb, axi_wlast}), 64'({wd, strb, 1'b1}));
        axi_wready = (w_cnt >= w_dly); w_cnt++;
        if (axi_wready) w_hs++;
      end
      w_pend = axi_wvalid && !axi_wready;
      if (ar_pend) check_eq("ar_held", 64'(axi_arvalid), 64'd1);
      if (ar_hs > 0) check_eq("ar_dropped", 64'(axi_arvalid), 64'd0);
      axi_arready = 1'b0;
      if (axi_arvalid) begin
        check_eq("araddr", 64'(axi_araddr), 64'(addr));
        check_eq("ar_fields", 64'({axi_arid, axi_arlen, axi_arsize, axi_arburst, axi_arlock, axi_arprot}),
                 64'({TID, 8'd0, 3'b010, 2'b01, 1'b0, 3'b000}));
        axi_arready = (ar_cnt >= aw_dly); ar_cnt++;
        if (axi_arready) ar_hs++;
      end
      ar_pend = axi_arvalid && !axi_arready;
      rsp_ready = 1'b0;
      if (rsp_valid) begin
        if (lat < 0) lat = k;
        check_eq("rsp_read_data", 64'(rsp_read_data), 64'(exp_data));
        check_eq("rsp_error", 64'(rsp_error), 64'(exp_err));
        rsp_ready = (rsp_cnt >= rsp_hold); rsp_cnt++;
        if (rsp_ready) done = 1;
      end else if (lat >= 0) begin
        check_eq("rsp_held", 64'(rsp_valid), 64'd1);
      end
      @(negedge clk);
    end
    slave_quiet();
    check_eq("rsp_done", 64'(done), 64'd1);
    check_eq("cmd_ready_after", 64'(cmd_ready), 64'd1);
    check_eq("rsp_valid_after", 64'(rsp_valid), 64'd0);
    check_eq("hs_counts", 64'({8'(aw_hs), 8'(w_hs), 8'(ar_hs), 8'(resp_hs)}),
             64'({8'(wr), 8'(wr), 8'(!wr), 8'd1}));
  endtask

  // Abandon a write by asserting reset between clock edges.
  task automatic abort_write(input int w_dly);
    int w_cnt;
    w_cnt = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 34'h100; cmd_write_data = 32'h55AA55AA;
    cmd_write_byteenable = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) begin
      axi_awready = axi_awvalid;
      axi_wready  = axi_wvalid && (w_cnt >= w_dly);
      if (axi_wvalid) w_cnt++;
      @(negedge clk);
    end
    slave_quiet();
    if (w_dly == 0) check_eq("pre_rst_bready", 64'(axi_bready), 64'd1);
    else check_eq("pre_rst_wvalid", 64'({axi_awvalid, axi_wvalid}), 64'b01);
    #2 rst = 1'b1;
    #1 check_eq("rst_async_clear",
                64'({axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready, rsp_valid, cmd_ready}),
                64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    repeat (3) begin
      axi_bvalid = 1'b1;
      check_eq("post_rst_quiet", 64'({rsp_valid, axi_awvalid, axi_wvalid, axi_bready}), 64'd0);
      @(negedge clk);
    end
    slave_quiet();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    bit wr;
    logic [AW-1:0] a;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_write_data = '0;
    cmd_write_byteenable = '0;
    slave_quiet();
    repeat (3) @(negedge clk);
    check_eq("reset_valids",
             64'({cmd_ready, rsp_valid, axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready}), 64'd0);
    check_eq("reset_rsp", 64'({rsp_error, rsp_read_data}), 64'd0);
    rst = 1'b0;

    do_txn(1, 34'h4000, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 2'b00, TID, 1, 32'h0, lat);
    check_eq("lat_write_min", 64'(lat), 64'd3);
    do_txn(1, 34'h8000, 32'h12345678, 4'h3, 2, 0, 0, 0, 2'b00, TID, 1, 32'h0, lat);
    check_eq("lat_write_aw_late", 64'(lat), 64'd5);
    do_txn(0, 34'hBFF8, 32'h0, 4'h0, 0, 0, 0, 4, 2'b00, TID, 1, 32'h00000123, lat);
    check_eq("lat_read_min", 64'(lat), 64'd3);
    do_txn(0, 34'hBFF8, 32'h0, 4'h0, 0, 0, 1, 0, 2'b11, TID, 1, 32'hCAFE0001, lat);
    do_txn(0, 34'hBFF8, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, TID + 4'd1, 1, 32'hCAFE0002, lat);
    do_txn(0, 34'h2_0000_0010, 32'h0, 4'h0, 1, 0, 0, 0, 2'b00, TID, 0, 32'hCAFE0003, lat);
    do_txn(1, 34'h3_FFFF_FFFC, 32'hA5A5A5A5, 4'h8, 0, 3, 2, 1, 2'b10, TID, 1, 32'h0, lat);
    do_txn(1, 34'h10, 32'h0BADF00D, 4'h1, 0, 0, 0, 0, 2'b00, TID + 4'd3, 1, 32'h0, lat);

    abort_write(0);
    abort_write(10);

    do_txn(0, 34'h1000, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, TID, 1, 32'h11112222, lat);
    check_eq("b2b_read_lat", 64'(lat), 64'd3);
    do_txn(1, 34'h1004, 32'h33334444, 4'hF, 0, 0, 0, 0, 2'b00, TID, 1, 32'h0, lat);
    check_eq("b2b_write_lat", 64'(lat), 64'd3);

    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom);
      a = AW'({$urandom, $urandom});
      a[1:0] = 2'b00;
      do_txn(wr, a, $urandom, 4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
             ($urandom_range(0, 4) == 0) ? TID + 4'd1 : TID,
             ($urandom_range(0, 5) != 0), $urandom, lat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
